uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter; successor to the fixed 8N1 transmitter.
- Data width is a parameter. Baud divisor, parity mode and stop-bit count are runtime inputs, captured per frame.
- Upstream interface is a valid/ready handshake.
- Sits between a byte/word source (e.g. a FIFO or command encoder) and the board TX pin.
- Provides a busy flag and a one-cycle frame-done pulse.

Parameters:
DATA_W, 8, data bits per frame (legal 5..9).
DIV_W, 16, width of the runtime baud divisor input.
DIV_RST, 434, divisor used when baud_div < 2 (50 MHz / 115200).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tx_din  in  DATA_W  word to send
tx_din_vld  in  1  source has a word
tx_din_rdy  out  1  block can accept a word (state IDLE)
baud_div  in  DIV_W  clocks per bit, sampled at accept
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none; sampled at accept
stop2  in  1  1 = two stop bits, 0 = one; sampled at accept
tx  out  1  serial line, registered, idle high
busy  out  1  high while a frame is in flight (state != IDLE)
tx_done  out  1  one-cycle pulse on the last clock of the final stop bit

Behaviour:
Reset (synchronous, rst=1 at a clk edge):
- state=IDLE, tx=1, busy=0, tx_done=0, tx_din_rdy=1.
- All counters and shadow registers are cleared.
- Reset mid-frame aborts the frame. tx returns to 1 at that edge; no tx_done pulse is produced.

Handshake:
- A word is accepted on a clk edge where tx_din_vld && tx_din_rdy.
- tx_din_rdy = (state==IDLE); it is a register decode, not combinational from vld.
- At accept the block captures tx_din, baud_div, parity_mode and stop2 into shadow registers. Changes to these inputs mid-frame have no effect.
- If the captured baud_div < 2, DIV_RST is used instead.

State machine: IDLE -> START -> DATA -> (PARITY if mode 01/10) -> STOP -> IDLE.
- Bit-period counter cnt_bps runs 0..div-1 while not IDLE. Bit advance occurs at cnt_bps==div-1.
- DATA: bit counter 0..DATA_W-1, LSB first.
- STOP: lasts 1 or 2 bit periods, per stop2.

tx timing:
- tx is registered and updates on the edge that enters each bit. First start-bit low = 1 clk after the accept edge.
- Each bit holds for exactly div clocks.

Parity:
- even = XOR of the data bits.
- odd = ~XOR of the data bits.

Frame duration:
- Frame clocks = div*(1+DATA_W+P+S), where P∈{0,1} and S∈{1,2}.
- tx_done is asserted on the final clock of the frame. The next edge returns to IDLE, so tx_din_rdy=1 one cycle after tx_done.
- Back-to-back frames therefore have exactly 1 idle-high clock between the stop bit and the next start bit.

Other rules:
- busy = (state != IDLE), registered.
- vld held high while busy is ignored; data is not lost, since the source keeps vld asserted until rdy.
- No counter wraps silently: cnt_bps is DIV_W bits and div ≤ 2^DIV_W-1.

Optional Feature:
UART_TX_PARITY_EN
- Defined: PARITY state and parity logic are built; parity_mode behaves as specified above.
- Undefined: the parity_mode port still exists but is ignored. Every frame has P=0 and no PARITY state is generated (smaller area).

Decomposition:
- Package uart_pkg holds:
  - parity-mode localparams PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10;
  - the state encoding (IDLE, START, DATA, PARITY, STOP);
  - DIV_RST.
- One natural sub-module: uart_baud_cnt. It is a loadable divisor counter with inputs clk, rst, en, div and output bit_tick (a pulse at count div-1). It is intended for reuse by a future uart_rx_cfg.

Test Plan:
- Reset, then idle 20 clk -> tx=1, busy=0, tx_din_rdy=1, tx_done never asserted.
- div=4, no parity, stop2=0, send 0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,1 with each bit held 4 clk; tx_done on clk 40 after the accept edge; rdy returns 1 clk later.
- div=4, even parity, send 0x07 -> parity bit 1; odd parity, send 0x07 -> parity bit 0; frame = 44 clk. With the macro undefined, the same stimulus gives a 40 clk frame and no parity bit.
- stop2=1, div=3, send 0xFF, then a second word held on vld -> stop high for 6 clk, exactly 1 idle clk, then the second start bit; second word captured correctly.
- Change baud_div from 4 to 8 mid-frame -> the current frame stays at 4 clk/bit; the next frame uses 8.
- Assert rst during data bit 3 -> tx=1 at the next edge, busy=0, no tx_done; baud_div=0 then gives DIV_RST (434) clk per bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter and future receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

   // Parity modes. Mode 2'b11 is not listed and is handled as no parity.
   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // Divisor used when the requested divisor is below 2 (50 MHz / 115200).
   localparam int DIV_RST = 434;

   // Transmitter frame state encoding.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period counter: counts 0..div-1 while enabled and pulses bit_tick at div-1.
// Latency: bit_tick is combinational from the count register; first tick div clocks after en rises.
// Backpressure: none; clearing en holds the count at zero.
module uart_baud_cnt #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             bit_tick
);

   logic [DIV_W-1:0] cnt;

   assign bit_tick = en && (cnt == div - 1'b1);

   // Count clocks within the current bit; restart at zero on each tick or when disabled.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt <= '0;
      end else if (bit_tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (divisor, parity, stop bits captured per frame); parity built only with UART_TX_PARITY_EN.
// Latency: start bit drives tx the clock after the accept edge; frame lasts div*(1+DATA_W+P+S) clocks.
// Backpressure: tx_din_rdy is high only in IDLE; a held tx_din_vld is accepted one clock after tx_done.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int DIV_W   = 16,
   parameter int DIV_RST = uart_pkg::DIV_RST
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_din,
   input  logic              tx_din_vld,
   output logic              tx_din_rdy,
   input  logic [DIV_W-1:0]  baud_div,
   input  logic [1:0]        parity_mode,
   input  logic              stop2,
   output logic              tx,
   output logic              busy,
   output logic              tx_done
);

   localparam int               BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
   localparam logic [DIV_W-1:0] DIV_DFLT = DIV_W'(DIV_RST);

   state_t             state;
   state_t             state_nxt;
   logic [DATA_W-1:0]  data_q;
   logic [DIV_W-1:0]   div_q;
   logic               stop2_q;
   logic [BIT_W-1:0]   bit_idx;
   logic [BIT_W-1:0]   bit_nxt;
   logic               stop_idx;
   logic               stop_nxt;
   logic               tx_nxt;
   logic               cnt_en;
   logic               bit_tick;
   logic               accept;

`ifdef UART_TX_PARITY_EN
   logic               par_en_q;
   logic               par_bit_q;
`else
   // Parity mode is accepted on the port but has no effect in this build.
   logic               unused_parity_mode;
   assign unused_parity_mode = ^parity_mode;
`endif

   assign tx_din_rdy = (state == IDLE);
   assign busy       = (state != IDLE);
   assign accept     = tx_din_vld && (state == IDLE);
   assign cnt_en     = (state != IDLE);

   uart_baud_cnt #(
      .DIV_W (DIV_W)
   ) u_baud_cnt (
      .clk      (clk),
      .rst      (rst),
      .en       (cnt_en),
      .div      (div_q),
      .bit_tick (bit_tick)
   );

   // Frame state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Frame sequencing: advance one field per bit period.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (tx_din_vld) state_nxt = START;
         end
         START: begin
            if (bit_tick) state_nxt = DATA;
         end
         DATA: begin
            if (bit_tick && (bit_idx == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
               state_nxt = par_en_q ? PARITY : STOP;
`else
               state_nxt = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_tick) state_nxt = STOP;
         end
`endif
         STOP: begin
            if (bit_tick && (stop_idx == stop2_q)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Bit/stop indices, next line level and the frame-done pulse.
   always_comb begin
      bit_nxt  = bit_idx;
      stop_nxt = stop_idx;
      tx_done  = 1'b0;
      case (state)
         IDLE: begin
            bit_nxt  = '0;
            stop_nxt = 1'b0;
         end
         START: begin
            if (bit_tick) bit_nxt = '0;
         end
         DATA: begin
            if (bit_tick && (bit_idx != LAST_BIT)) bit_nxt = bit_idx + 1'b1;
         end
         STOP: begin
            if (bit_tick) begin
               stop_nxt = 1'b1;
               tx_done  = (stop_idx == stop2_q);
            end
         end
         default: begin
            bit_nxt  = bit_idx;
            stop_nxt = stop_idx;
         end
      endcase

      // tx is registered, so it takes the level of the bit being entered.
      tx_nxt = 1'b1;
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = data_q[bit_nxt];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_nxt = par_bit_q;
`endif
         default: tx_nxt = 1'b1;
      endcase
   end

   // Line register, counters and per-frame shadow copies of the configuration.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx       <= 1'b1;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         data_q   <= '0;
         div_q    <= '0;
         stop2_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
`endif
      end else begin
         tx       <= tx_nxt;
         bit_idx  <= bit_nxt;
         stop_idx <= stop_nxt;
         if (accept) begin
            data_q  <= tx_din;
            div_q   <= (baud_div < DIV_W'(2)) ? DIV_DFLT : baud_div;
            stop2_q <= stop2;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
            par_bit_q <= (parity_mode == PAR_ODD) ? ~(^tx_din) : ^tx_din;
`endif
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: per-cycle expected line waveform queued at each accept and compared every clock.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_cfg;
   import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  tx_din = '0;
   logic        tx_din_vld = 1'b0;
   logic        tx_din_rdy;
   logic [15:0] baud_div = 16'd4;
   logic [1:0]  parity_mode = 2'b00;
   logic        stop2 = 1'b0;
   logic        tx;
   logic        busy;
   logic        tx_done;

   always #5 clk = ~clk;

   uart_tx_cfg dut (
      .clk         (clk),
      .rst         (rst),
      .tx_din      (tx_din),
      .tx_din_vld  (tx_din_vld),
      .tx_din_rdy  (tx_din_rdy),
      .baud_div    (baud_div),
      .parity_mode (parity_mode),
      .stop2       (stop2),
      .tx          (tx),
      .busy        (busy),
      .tx_done     (tx_done)
   );

   typedef struct {
      logic [7:0] data;
      int         div;
      logic [1:0] pm;
      logic       s2;
      int         par;   // expected parity bit, -1 when no parity bit is sent
      int         clks;  // expected frame length in clocks
   } vec_t;

   vec_t       vecs [6];
   // Expected {tx, busy, tx_done, tx_din_rdy} for each clock, in order.
   logic [3:0] exp_q [$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         done_cnt = 0;
   int         done_cyc = 0;
   int         acc_cyc = 0;
   int         exp_frames = 0;
   bit         chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
   end

   always @(negedge clk) begin
      logic [3:0] e;
      logic [3:0] o;
      if (chk_en) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b1001;
         o = {tx, busy, tx_done, tx_din_rdy};
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL stream cyc=%0d tx/busy/done/rdy got %b want %b", cyc, o, e);
         end
      end
   end

   task automatic push_frame(input logic [7:0] data, input int div, input int par, input logic s2);
      int total;
      for (int n = 0; n < div; n++) exp_q.push_back(4'b0100);
      for (int i = 0; i < 8; i++)
         for (int n = 0; n < div; n++) exp_q.push_back({data[i], 3'b100});
      if (par >= 0)
         for (int n = 0; n < div; n++) exp_q.push_back({par[0], 3'b100});
      total = div * (s2 ? 2 : 1);
      for (int n = 0; n < total; n++)
         exp_q.push_back((n == total - 1) ? 4'b1110 : 4'b1100);
      exp_q.push_back(4'b1001);
      exp_frames++;
   endtask

   task automatic send(input logic [7:0] data, input int div, input logic [1:0] pm,
                       input logic s2, input int par);
      int budget = 0;
      @(negedge clk);
      tx_din      = data;
      baud_div    = 16'(div);
      parity_mode = pm;
      stop2       = s2;
      tx_din_vld  = 1'b1;
      while (!tx_din_rdy) begin
         @(negedge clk);
         budget++;
         if (budget > 20000) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout data=%h got rdy=%b want 1", data, tx_din_rdy);
            tx_din_vld = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      tx_din_vld = 1'b0;
      acc_cyc    = cyc;
      push_frame(data, (div < 2) ? 434 : div, par, s2);
   endtask

   task automatic wait_done(input int target);
      int budget = 0;
      while (done_cnt < target) begin
         @(negedge clk);
         budget++;
         if (budget > 20000) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got done_cnt=%0d want %0d", done_cnt, target);
            return;
         end
      end
   endtask

   task automatic check_len(input string name, input int exp_clks);
      checks++;
      if (done_cyc - acc_cyc + 1 != exp_clks) begin
         errors++;
         $display("FAIL %s frame clocks got %0d want %0d", name, done_cyc - acc_cyc + 1, exp_clks);
      end
   endtask

   initial begin
      #600000;
      $display("FAIL global_timeout got time %0t want finish earlier", $time);
      $fatal(1, "bench timeout");
   end

   initial begin
      int acc1;
      int prev;

      vecs[0] = '{8'h55, 4, PAR_NONE, 1'b0, -1, 40};
      vecs[1] = '{8'h07, 4, PAR_EVEN, 1'b0, (PB != 0) ? 1 : -1, 4 * (10 + PB)};
      vecs[2] = '{8'h07, 4, PAR_ODD,  1'b0, (PB != 0) ? 0 : -1, 4 * (10 + PB)};
      vecs[3] = '{8'hA3, 2, PAR_NONE, 1'b1, -1, 22};
      vecs[4] = '{8'h00, 5, 2'b11,    1'b0, -1, 50};
      vecs[5] = '{8'h3C, 3, PAR_ODD,  1'b1, (PB != 0) ? 1 : -1, 3 * (11 + PB)};

      // Reset state while rst is held.
      repeat (2) @(negedge clk);
      checks++;
      if ({tx, busy, tx_done, tx_din_rdy} !== 4'b1001) begin
         errors++;
         $display("FAIL reset_state tx/busy/done/rdy got %b want 1001", {tx, busy, tx_done, tx_din_rdy});
      end
      rst    = 1'b0;
      chk_en = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (done_cnt != 0) begin
         errors++;
         $display("FAIL idle_no_done got %0d pulses want 0", done_cnt);
      end

      // Table of single frames.
      foreach (vecs[k]) begin
         prev = done_cnt;
         send(vecs[k].data, vecs[k].div, vecs[k].pm, vecs[k].s2, vecs[k].par);
         wait_done(prev + 1);
         check_len($sformatf("vec%0d", k), vecs[k].clks);
      end

      // Two stop bits, second word held on vld while busy.
      prev = done_cnt;
      send(8'hFF, 3, PAR_NONE, 1'b1, -1);
      acc1 = acc_cyc;
      send(8'h96, 3, PAR_NONE, 1'b0, -1);
      checks++;
      if (acc_cyc - acc1 != 34) begin
         errors++;
         $display("FAIL b2b_gap accept spacing got %0d want 34", acc_cyc - acc1);
      end
      wait_done(prev + 2);
      check_len("b2b_second", 30);

      // Divisor changed mid-frame applies only to the next frame.
      prev = done_cnt;
      send(8'h33, 4, PAR_NONE, 1'b0, -1);
      baud_div = 16'd8;
      wait_done(prev + 1);
      check_len("div_change_cur", 40);
      send(8'hC6, 8, PAR_NONE, 1'b0, -1);
      wait_done(prev + 2);
      check_len("div_change_next", 80);

      // Reset during data bit 3 aborts the frame without a done pulse.
      send(8'h55, 4, PAR_NONE, 1'b0, -1);
      repeat (17) @(negedge clk);
      chk_en = 1'b0;
      prev   = done_cnt;
      rst    = 1'b1;
      @(negedge clk);
      checks++;
      if ({tx, busy, tx_done, tx_din_rdy} !== 4'b1001) begin
         errors++;
         $display("FAIL rst_abort tx/busy/done/rdy got %b want 1001", {tx, busy, tx_done, tx_din_rdy});
      end
      rst = 1'b0;
      exp_q.delete();
      exp_frames--;
      chk_en = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (done_cnt != prev) begin
         errors++;
         $display("FAIL abort_no_done got %0d pulses want 0", done_cnt - prev);
      end

      // Divisor 0 falls back to 434 clocks per bit.
      send(8'h5A, 0, PAR_NONE, 1'b0, -1);
      wait_done(prev + 1);
      check_len("div_zero", 4340);

      repeat (5) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL stream_drain got %0d entries left want 0", exp_q.size());
      end
      checks++;
      if (done_cnt != exp_frames) begin
         errors++;
         $display("FAIL done_total got %0d want %0d", done_cnt, exp_frames);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
